operand_feeder: RTL

Upstream stage of the `simpletest` datapath. Accepts a byte stream over a valid/ready handshake, assembles each command triple (command byte, operand A, operand B), buffers complete triples in a small FIFO, and issues at most one triple per cycle on registered `sel`/`in1`/`in2` outputs wired directly to the datapath inputs. Cycles with nothing to issue drive an idle encoding whose datapath result is zero.

---
 rtl/operand_feeder_pkg.sv | 22 ++
 rtl/op_fifo.sv | 48 ++++
 rtl/operand_feeder.sv | 97 +++++++++
 3 files changed

// File: rtl/operand_feeder_pkg.sv
// Shared types and constants for the operand feeder: assembler states,
// idle/command encodings and the buffered triple layout.
package operand_feeder_pkg;

    localparam int OP_W = 8;

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        WAIT_A   = 2'd1,
        WAIT_B   = 2'd2
    } asm_state_t;

    localparam logic [1:0] SEL_IDLE      = 2'b11;
    localparam logic [7:0] CMD_RSVD_MASK = 8'hFC;

    typedef struct packed {
        logic [1:0]      sel;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } fifo_entry_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous FIFO with a level counter; read data is valid in any cycle
// where empty is low (show-ahead, no bypass from write to read).
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/operand_feeder.sv
// Assembles cmd/A/B byte triples from a valid/ready stream, queues them, and
// drives registered sel/in1/in2 to the datapath, idling when nothing issues.
module operand_feeder
    import operand_feeder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = OP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   stall,
    output logic [1:0]             sel,
    output logic [DATA_W-1:0]      in1,
    output logic [DATA_W-1:0]      in2,
    output logic                   issue_valid,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             err_cnt
);
    asm_state_t       state, state_nx;
    logic [1:0]       cmd_sel;
    logic [DATA_W-1:0] opa;
    logic             accept, cmd_ok, push, pop, full, empty, err_inc;
    fifo_entry_t      wentry, rentry;

    // Ready depends only on state and the registered level, never on s_valid.
    assign s_ready = (state != WAIT_B) || !full;
    assign accept  = s_valid && s_ready;
    assign cmd_ok  = (s_data & CMD_RSVD_MASK) == '0;
    assign push    = accept && (state == WAIT_B);
    assign pop     = !empty && !stall;
    assign err_inc = accept && (state == WAIT_CMD) && !cmd_ok;
    assign wentry  = '{sel: cmd_sel, a: opa, b: s_data};

    op_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (rentry),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_CMD: if (accept && cmd_ok) state_nx = WAIT_A;
            WAIT_A:   if (accept)           state_nx = WAIT_B;
            WAIT_B:   if (accept)           state_nx = WAIT_CMD;
            default:                        state_nx = WAIT_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_CMD;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_sel <= '0;
            opa     <= '0;
        end else if (accept) begin
            if (state == WAIT_CMD) cmd_sel <= s_data[1:0];
            if (state == WAIT_A)   opa     <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                             err_cnt <= '0;
        else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

    // The datapath samples every cycle, so non-issue cycles must drive idle.
    always_ff @(posedge clk) begin
        if (rst || !pop) begin
            sel         <= SEL_IDLE;
            in1         <= '0;
            in2         <= '0;
            issue_valid <= 1'b0;
        end else begin
            sel         <= rentry.sel;
            in1         <= rentry.a;
            in2         <= rentry.b;
            issue_valid <= 1'b1;
        end
    end

endmodule
